// File: rtl/tpram_sfifo_pkg.sv
// rtl/tpram_sfifo_pkg.sv - shared defaults and width helpers for tpram_sfifo
package tpram_sfifo_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DATA_DEPTH = 16;
  localparam int DEF_RD_DELAY   = 1;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Total count spans RAM, reads in flight and the RD_DELAY+1 entry output buffer.
  function automatic int count_width(input int depth, input int rd_delay);
    return $clog2(depth + rd_delay + 2);
  endfunction

  function automatic int obuf_width(input int rd_delay);
    return $clog2(rd_delay + 2);
  endfunction

  function automatic int be_width(input int data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/tpram_sfifo_tpram.sv
// rtl/tpram_sfifo_tpram.sv - two-port RAM, port a writes with byte enables, port b reads with RD_DELAY latency
module tpram_sfifo_tpram
  import tpram_sfifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int  RD_DELAY   = DEF_RD_DELAY,
  localparam int AW         = ptr_width(DATA_DEPTH),
  localparam int BW         = be_width(DATA_WIDTH)
) (
  input  logic                  clka,
  input  logic                  wea,
  input  logic [BW-1:0]         bwea,
  input  logic [AW-1:0]         addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  clkb,
  input  logic                  enb,
  input  logic [AW-1:0]         addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  logic [DATA_WIDTH-1:0] mem  [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] pipe [RD_DELAY];

  always_ff @(posedge clka) begin
    if (wea) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (bwea[i/8]) mem[addra][i] <= dina[i];
      end
    end
  end

  // First stage loads only on enb; later stages shift freely so data keeps its issue timing.
  always_ff @(posedge clkb) begin
    if (enb) pipe[0] <= mem[addrb];
    for (int k = 1; k < RD_DELAY; k++) pipe[k] <= pipe[k-1];
  end

  assign doutb = pipe[RD_DELAY-1];

endmodule

// File: rtl/tpram_sfifo.sv
// rtl/tpram_sfifo.sv - synchronous FWFT FIFO built on a latency-RD_DELAY two-port RAM with prefetch buffer
module tpram_sfifo
  import tpram_sfifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int  RD_DELAY   = DEF_RD_DELAY,
  parameter int  AF_LEVEL   = DATA_DEPTH - 2,
  parameter int  AE_LEVEL   = 2,
  localparam int CW         = count_width(DATA_DEPTH, RD_DELAY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow
);

  localparam int              AW       = ptr_width(DATA_DEPTH);
  localparam int              OW       = obuf_width(RD_DELAY);
  localparam int              OB_N     = RD_DELAY + 1;
  localparam int              BW       = be_width(DATA_WIDTH);
  localparam logic [AW-1:0]   PTR_LAST = AW'(DATA_DEPTH - 1);
  localparam logic [CW-1:0]   RAM_FULL = CW'(DATA_DEPTH);
  localparam logic [CW-1:0]   OB_CAP   = CW'(OB_N);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         ram_cnt;
  logic [CW-1:0]         inflight;
  logic [OW-1:0]         ob_cnt;
  logic [OW-1:0]         cap_idx;
  logic [RD_DELAY-1:0]   vld_pipe;
  logic [DATA_WIDTH-1:0] obuf [OB_N];
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  rdy_en;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  capture;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_DELAY; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  assign wr_rdy  = rdy_en && (ram_cnt < RAM_FULL) && !clr;
  assign rd_vld  = (ob_cnt != '0);
  assign rd_data = obuf[0];
  assign push    = wr_vld && wr_rdy;
  assign pop     = rd_vld && rd_rdy && !clr;
  assign capture = vld_pipe[RD_DELAY-1];
  assign cap_idx = ob_cnt - OW'(pop);

  // A pop this cycle frees an output slot, which keeps one word per clock in steady state.
  assign issue = !clr && (ram_cnt != '0) &&
                 ((CW'(ob_cnt) + inflight - CW'(pop)) < OB_CAP);

  assign count        = ram_cnt + inflight + CW'(ob_cnt);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      vld_pipe <= '0;
      ob_cnt   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < OB_N; i++) obuf[i] <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ram_cnt  <= '0;
        vld_pipe <= '0;
        ob_cnt   <= '0;
        overflow <= 1'b0;
        for (int i = 0; i < OB_N; i++) obuf[i] <= '0;
      end else begin
        if (wr_vld && !wr_rdy) overflow <= 1'b1;
        if (push)  wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (issue) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        ram_cnt  <= ram_cnt + CW'(push) - CW'(issue);
        vld_pipe <= (vld_pipe << 1) | RD_DELAY'(issue);
        if (pop) begin
          for (int i = 0; i < OB_N - 1; i++) obuf[i] <= obuf[i+1];
        end
        // Capture lands after the shift so a simultaneous pop and capture both take effect.
        if (capture) obuf[cap_idx] <= ram_dout;
        ob_cnt <= ob_cnt + OW'(capture) - OW'(pop);
      end
    end
  end

  tpram_sfifo_tpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_DEPTH(DATA_DEPTH),
    .RD_DELAY  (RD_DELAY)
  ) u_ram (
    .clka (clk),
    .wea  (push),
    .bwea ({BW{1'b1}}),
    .addra(wr_ptr),
    .dina (wr_data),
    .clkb (clk),
    .enb  (issue),
    .addrb(rd_ptr),
    .doutb(ram_dout)
  );

endmodule

// File: tb/tb_tpram_sfifo.sv
// tb/tb_tpram_sfifo.sv - directed bench for tpram_sfifo over three depth/latency configurations
module tb_tpram_sfifo;

  localparam int NI = 3;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   [NI];
  logic          clr     [NI];
  logic          wr_vld  [NI];
  logic [DW-1:0] wr_data [NI];
  logic          rd_rdy  [NI];
  wire           wr_rdy  [NI];
  wire           rd_vld  [NI];
  wire  [DW-1:0] rd_data [NI];
  wire  [7:0]    count   [NI];
  wire           afull   [NI];
  wire           aempty  [NI];
  wire           ovf     [NI];

  // Instance 0: depth 16 / delay 1, instance 1: depth 16 / delay 2, instance 2: depth 12 / delay 3.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DEP = (g == 2) ? 12 : 16;
    localparam int RDD = g + 1;
    localparam int CW  = $clog2(DEP + RDD + 2);
    wire [CW-1:0] cnt;
    tpram_sfifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEP), .RD_DELAY(RDD)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .clr         (clr[g]),
      .wr_vld      (wr_vld[g]),
      .wr_rdy      (wr_rdy[g]),
      .wr_data     (wr_data[g]),
      .rd_vld      (rd_vld[g]),
      .rd_rdy      (rd_rdy[g]),
      .rd_data     (rd_data[g]),
      .count       (cnt),
      .almost_full (afull[g]),
      .almost_empty(aempty[g]),
      .overflow    (ovf[g])
    );
    assign count[g] = 8'(cnt);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time %0t exceeded limit 300000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   wd;
    int   rx;
    int   cyc;
    logic acc_w;

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; clr[i] = 1'b0; wr_vld[i] = 1'b0; wr_data[i] = '0; rd_rdy[i] = 1'b0;
    end
    step(2);
    for (int i = 0; i < NI; i++) begin
      chk("rst_rd_vld", rd_vld[i], 0);
      chk("rst_wr_rdy", wr_rdy[i], 0);
      chk("rst_count", count[i], 0);
      chk("rst_afull", afull[i], 0);
      chk("rst_aempty", aempty[i], 1);
      chk("rst_ovf", ovf[i], 0);
      chk("rst_rd_data", rd_data[i], 0);
    end
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    #1;
    chk("rel_wr_rdy_low", wr_rdy[0], 0);
    step();
    for (int i = 0; i < NI; i++) chk("rel_wr_rdy_high", wr_rdy[i], 1);

    // Single word latency, RD_DELAY=1: visible two edges after the write.
    wr_vld[0] = 1'b1; wr_data[0] = 16'h00A5;
    step();
    wr_vld[0] = 1'b0;
    chk("lat_cnt_n", count[0], 1);
    chk("lat_vld_n", rd_vld[0], 0);
    step();
    chk("lat_vld_n1", rd_vld[0], 0);
    chk("lat_cnt_n1", count[0], 1);
    step();
    chk("lat_vld_n2", rd_vld[0], 1);
    chk("lat_data_n2", rd_data[0], 16'h00A5);
    chk("lat_cnt_n2", count[0], 1);
    chk("lat_aempty", aempty[0], 1);
    rd_rdy[0] = 1'b1;
    step();
    rd_rdy[0] = 1'b0;
    chk("lat_pop_vld", rd_vld[0], 0);
    chk("lat_pop_cnt", count[0], 0);

    // Continuous streaming: one word per clock after a three-cycle fill.
    for (int i = 0; i < 1003; i++) begin
      wr_vld[0] = (i < 1000);
      wr_data[0] = DW'(i);
      rd_rdy[0] = 1'b1;
      if (i >= 3) begin
        chk("stream_vld", rd_vld[0], 1);
        chk("stream_data", rd_data[0], 32'(i - 3));
      end
      if (i == 500) chk("stream_cnt", count[0], 3);
      step();
    end
    wr_vld[0] = 1'b0; rd_rdy[0] = 1'b0;
    chk("stream_end_cnt", count[0], 0);
    chk("stream_end_vld", rd_vld[0], 0);

    // Fill to capacity with no reads: 16 in RAM plus 3 in the output buffer.
    for (int v = 0; v < 31; v++) begin
      wr_vld[1] = 1'b1;
      wr_data[1] = DW'(v);
      if (v < 19) chk("full_wr_rdy_hi", wr_rdy[1], 1);
      if (v == 19) begin
        chk("full_wr_rdy_lo", wr_rdy[1], 0);
        chk("full_cnt", count[1], 19);
        chk("full_ovf_before", ovf[1], 0);
        chk("full_afull", afull[1], 1);
        chk("full_aempty", aempty[1], 0);
      end
      if (v == 20) chk("full_ovf_set", ovf[1], 1);
      step();
    end
    wr_vld[1] = 1'b0;
    chk("full_cnt_hold", count[1], 19);
    rd_rdy[1] = 1'b1;
    for (int j = 0; j < 19; j++) begin
      chk("drain_vld", rd_vld[1], 1);
      chk("drain_data", rd_data[1], j);
      step();
    end
    chk("drain_empty", rd_vld[1], 0);
    chk("drain_cnt", count[1], 0);
    chk("drain_ovf_sticky", ovf[1], 1);
    rd_rdy[1] = 1'b0;
    clr[1] = 1'b1;
    #1;
    chk("clr_wr_rdy", wr_rdy[1], 0);
    step();
    clr[1] = 1'b0;
    chk("clr_ovf", ovf[1], 0);

    // Depth 12: 50 words through with a mostly-stalled reader so pointers wrap while full.
    wd = 0; rx = 0; cyc = 0;
    while (rx < 50 && cyc < 3000) begin
      wr_vld[2] = (wd < 50);
      wr_data[2] = DW'(wd);
      rd_rdy[2] = ($urandom_range(0, 2) == 0);
      acc_w = wr_vld[2] && wr_rdy[2];
      if (rd_vld[2] && rd_rdy[2]) begin
        chk("wrap_data", rd_data[2], rx);
        rx++;
      end
      step();
      if (acc_w) wd++;
      cyc++;
    end
    chk("wrap_done", rx, 50);
    wr_vld[2] = 1'b0; rd_rdy[2] = 1'b0;
    step();
    chk("wrap_end_cnt", count[2], 0);

    // Flush with 3 reads in flight and 8 words held.
    for (int k = 0; k < 8; k++) begin
      wr_vld[2] = 1'b1; wr_data[2] = DW'(16'h0200 + k);
      step();
    end
    wr_vld[2] = 1'b0;
    step(3);
    chk("pre_clr_cnt", count[2], 8);
    chk("pre_clr_head", rd_data[2], 16'h0200);
    for (int k = 0; k < 3; k++) begin
      wr_vld[2] = 1'b1; wr_data[2] = DW'(16'h0300 + k); rd_rdy[2] = 1'b1;
      chk("pre_clr_pop", rd_data[2], 32'(16'h0200 + k));
      step();
    end
    chk("pre_clr_cnt8", count[2], 8);
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0; wr_vld[2] = 1'b0; rd_rdy[2] = 1'b0;
    chk("clr_cnt", count[2], 0);
    chk("clr_vld", rd_vld[2], 0);
    chk("clr_ovf2", ovf[2], 0);
    chk("clr_aempty", aempty[2], 1);
    wr_vld[2] = 1'b1; wr_data[2] = 16'h0055;
    step();
    wr_vld[2] = 1'b0;
    step(3);
    chk("post_clr_vld_early", rd_vld[2], 0);
    chk("post_clr_cnt", count[2], 1);
    step();
    chk("post_clr_vld", rd_vld[2], 1);
    chk("post_clr_data", rd_data[2], 16'h0055);

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 5; k++) begin
      wr_vld[0] = 1'b1; wr_data[0] = DW'(16'h0010 + k);
      step();
    end
    chk("mid_head", rd_data[0], 16'h0010);
    rst_n[0] = 1'b0;
    #1;
    chk("mid_rst_vld", rd_vld[0], 0);
    chk("mid_rst_wr_rdy", wr_rdy[0], 0);
    chk("mid_rst_cnt", count[0], 0);
    chk("mid_rst_afull", afull[0], 0);
    chk("mid_rst_aempty", aempty[0], 1);
    chk("mid_rst_ovf", ovf[0], 0);
    chk("mid_rst_data", rd_data[0], 0);
    step();
    rst_n[0] = 1'b1; wr_vld[0] = 1'b0;
    chk("mid_rel_wr_rdy_lo", wr_rdy[0], 0);
    step();
    chk("mid_rel_wr_rdy_hi", wr_rdy[0], 1);
    chk("mid_rel_cnt", count[0], 0);
    chk("mid_rel_vld", rd_vld[0], 0);
    wr_vld[0] = 1'b1; wr_data[0] = 16'h0077;
    step();
    wr_vld[0] = 1'b0;
    step(2);
    chk("mid_new_vld", rd_vld[0], 1);
    chk("mid_new_data", rd_data[0], 16'h0077);
    chk("mid_new_cnt", count[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
